// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage in-order
// pipeline. It drives stall/flush controls for the fetch, decode, execute and
// memory pipeline registers and selects execute-stage forwarding sources. It
// sequences a data-cache wait (MEM_WAIT), the post-mispredict redirect window
// (REDIRECT) and trap flushes. Load-use bubbles last one cycle.
//
// Ports:
//   i_clk, i_arst            clock, asynchronous active-high reset
//   i_rs*_addr_dec/_exec     source registers in decode / execute
//   i_rd_addr_{exec,mem,wb}  destination registers down the pipe
//   i_reg_we_{mem,wb}        register write enables in mem / writeback
//   i_load_instr_exec        execute holds a load
//   i_mispredict, i_trap     control events resolved in execute
//   i_icache_stall           fetch miss in progress
//   i_dcache_stall           memory-stage miss in progress
//   o_stall_*, o_flush_*     pipeline register hold / clear
//   o_forward_rs{1,2}        00 regfile, 01 writeback, 10 memory
//   o_stall_count            cycles with any stall     (HAZARD_PERF_EN)
//   o_flush_count            trap/mispredict/load-use  (HAZARD_PERF_EN)
//
// Build option: define HAZARD_PERF_EN to add the two performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W      = 5,
    parameter int REDIRECT_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
    input  logic                  i_load_instr_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
    input  logic                  i_reg_we_mem,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
    input  logic                  i_reg_we_wb,
    input  logic                  i_mispredict,
    input  logic                  i_trap,
    input  logic                  i_icache_stall,
    input  logic                  i_dcache_stall,
    output logic                  o_stall_fetch,
    output logic                  o_stall_dec,
    output logic                  o_stall_exec,
    output logic                  o_stall_mem,
    output logic                  o_flush_dec,
    output logic                  o_flush_exec,
    output logic                  o_flush_mem,
    output logic [1:0]            o_forward_rs1,
    output logic [1:0]            o_forward_rs2
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           o_stall_count,
    output logic [31:0]           o_flush_count
`endif
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

    state_t     state, state_nxt;
    logic       saved_redir, saved_redir_nxt;  // state to resume after MEM_WAIT
    logic [2:0] redir_cnt, redir_cnt_nxt;
    logic       in_redirect;
    logic       load_use;
    logic       mem_hit1, wb_hit1, mem_hit2, wb_hit2;

    // Forwarding, memory stage wins over writeback; x0 is never forwarded.
    assign mem_hit1 = i_reg_we_mem && (i_rd_addr_mem != '0) && (i_rd_addr_mem == i_rs1_addr_exec);
    assign wb_hit1  = i_reg_we_wb  && (i_rd_addr_wb  != '0) && (i_rd_addr_wb  == i_rs1_addr_exec);
    assign mem_hit2 = i_reg_we_mem && (i_rd_addr_mem != '0) && (i_rd_addr_mem == i_rs2_addr_exec);
    assign wb_hit2  = i_reg_we_wb  && (i_rd_addr_wb  != '0) && (i_rd_addr_wb  == i_rs2_addr_exec);

    assign load_use = i_load_instr_exec && (i_rd_addr_exec != '0) &&
                      ((i_rd_addr_exec == i_rs1_addr_dec) || (i_rd_addr_exec == i_rs2_addr_dec));

    // The cycle the dcache stall drops, MEM_WAIT already behaves as the saved
    // state so events held in execute are served with no extra bubble.
    assign in_redirect = (state == REDIRECT) || ((state == MEM_WAIT) && saved_redir);

    always_comb begin
        state_nxt       = in_redirect ? REDIRECT : RUN;
        saved_redir_nxt = saved_redir;
        redir_cnt_nxt   = redir_cnt;
        o_stall_fetch   = 1'b0;
        o_stall_dec     = 1'b0;
        o_stall_exec    = 1'b0;
        o_stall_mem     = 1'b0;
        o_flush_dec     = 1'b0;
        o_flush_exec    = 1'b0;
        o_flush_mem     = 1'b0;
        o_forward_rs1   = mem_hit1 ? 2'b10 : (wb_hit1 ? 2'b01 : 2'b00);
        o_forward_rs2   = mem_hit2 ? 2'b10 : (wb_hit2 ? 2'b01 : 2'b00);

        if (i_dcache_stall) begin
            // Freeze everything; trap/mispredict stay pending in execute.
            {o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem} = 4'hF;
            state_nxt       = MEM_WAIT;
            saved_redir_nxt = in_redirect;
        end else if (i_trap) begin
            {o_flush_dec, o_flush_exec, o_flush_mem} = 3'b111;
            state_nxt     = RUN;
            redir_cnt_nxt = 3'd0;
        end else if (i_mispredict) begin
            o_flush_dec   = 1'b1;
            o_flush_exec  = 1'b1;
            redir_cnt_nxt = 3'(REDIRECT_CYCLES);
            state_nxt     = (REDIRECT_CYCLES > 0) ? REDIRECT : RUN;
        end else if (in_redirect) begin
            // Decode is flushed anyway, so load-use needs no bubble here.
            o_flush_dec   = 1'b1;
            o_stall_fetch = i_icache_stall;
            redir_cnt_nxt = redir_cnt - 3'd1;
            if (redir_cnt <= 3'd1) state_nxt = RUN;
        end else if (load_use) begin
            // Covers a concurrent icache miss too: decode must hold, not clear.
            o_stall_fetch = 1'b1;
            o_stall_dec   = 1'b1;
            o_flush_exec  = 1'b1;
        end else if (i_icache_stall) begin
            o_stall_fetch = 1'b1;
            o_flush_dec   = 1'b1;
        end

        if (i_arst) begin
            {o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem} = 4'h0;
            {o_flush_dec, o_flush_exec, o_flush_mem} = 3'b000;
            o_forward_rs1 = 2'b00;
            o_forward_rs2 = 2'b00;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state       <= RUN;
            saved_redir <= 1'b0;
            redir_cnt   <= 3'd0;
        end else begin
            state       <= state_nxt;
            saved_redir <= saved_redir_nxt;
            redir_cnt   <= redir_cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    logic any_stall, flush_event;

    assign any_stall   = o_stall_fetch | o_stall_dec | o_stall_exec | o_stall_mem;
    assign flush_event = !i_dcache_stall &&
                         (i_trap || i_mispredict || (!in_redirect && load_use));

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_stall_count <= 32'd0;
            o_flush_count <= 32'd0;
        end else begin
            if (any_stall)   o_stall_count <= o_stall_count + 32'd1;
            if (flush_event) o_flush_count <= o_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by randomized stimulus.
// A driver applies one stimulus per cycle and pushes the reference model's
// expectation; a monitor on the falling edge pops and compares.
module tb_pipe_hazard_ctrl;
    localparam int AW = 5;
    localparam int RC = 2;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic          arst;
        logic [AW-1:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec, rd_mem, rd_wb;
        logic          load, we_mem, we_wb, mis, trap, ic, dc;
    } stim_t;

    typedef struct packed {
        logic [3:0]  stall;  // fetch, dec, exec, mem
        logic [2:0]  flush;  // dec, exec, mem
        logic [1:0]  f1, f2;
        logic [31:0] sc, fc;
    } exp_t;

    stim_t s_cur = '0;
    logic o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem;
    logic o_flush_dec, o_flush_exec, o_flush_mem;
    logic [1:0] o_forward_rs1, o_forward_rs2;
`ifdef HAZARD_PERF_EN
    logic [31:0] o_stall_count, o_flush_count;
`endif

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .REDIRECT_CYCLES(RC)) dut (
        .i_clk(i_clk), .i_arst(s_cur.arst),
        .i_rs1_addr_dec(s_cur.rs1_dec), .i_rs2_addr_dec(s_cur.rs2_dec),
        .i_rs1_addr_exec(s_cur.rs1_exec), .i_rs2_addr_exec(s_cur.rs2_exec),
        .i_rd_addr_exec(s_cur.rd_exec), .i_load_instr_exec(s_cur.load),
        .i_rd_addr_mem(s_cur.rd_mem), .i_reg_we_mem(s_cur.we_mem),
        .i_rd_addr_wb(s_cur.rd_wb), .i_reg_we_wb(s_cur.we_wb),
        .i_mispredict(s_cur.mis), .i_trap(s_cur.trap),
        .i_icache_stall(s_cur.ic), .i_dcache_stall(s_cur.dc),
        .o_stall_fetch(o_stall_fetch), .o_stall_dec(o_stall_dec),
        .o_stall_exec(o_stall_exec), .o_stall_mem(o_stall_mem),
        .o_flush_dec(o_flush_dec), .o_flush_exec(o_flush_exec), .o_flush_mem(o_flush_mem),
        .o_forward_rs1(o_forward_rs1), .o_forward_rs2(o_forward_rs2)
`ifdef HAZARD_PERF_EN
        , .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
`endif
    );

    // Reference model: redirect cycles left (0 = not redirecting), frozen
    // during a data-cache wait; plain event counters.
    int          m_left = 0;
    logic [31:0] m_stalls = 0, m_flushes = 0;
    exp_t        exp_q[$];
    int          checks = 0, failures = 0;

    function automatic logic [1:0] fwd(input stim_t s, input logic [AW-1:0] rs);
        if (s.we_mem && s.rd_mem != 0 && s.rd_mem == rs) return 2'b10;
        if (s.we_wb && s.rd_wb != 0 && s.rd_wb == rs)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic model(input stim_t s, output exp_t e);
        logic lu;
        e = '0;
        if (s.arst) begin
            m_left = 0; m_stalls = 0; m_flushes = 0;
            return;
        end
        e.sc = m_stalls;
        e.fc = m_flushes;
        e.f1 = fwd(s, s.rs1_exec);
        e.f2 = fwd(s, s.rs2_exec);
        lu = s.load && s.rd_exec != 0 && (s.rd_exec == s.rs1_dec || s.rd_exec == s.rs2_dec);
        if (s.dc) begin
            e.stall = 4'b1111;
        end else if (s.trap) begin
            e.flush = 3'b111; m_left = 0; m_flushes++;
        end else if (s.mis) begin
            e.flush = 3'b110; m_left = RC; m_flushes++;
        end else if (m_left > 0) begin
            e.flush = 3'b100; m_left--;
            if (s.ic) e.stall = 4'b1000;
        end else if (lu) begin
            e.stall = 4'b1100; e.flush = 3'b010; m_flushes++;
        end else if (s.ic) begin
            e.stall = 4'b1000; e.flush = 3'b100;
        end
        if (e.stall != 0) m_stalls++;
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        @(posedge i_clk);
        #1;
        s_cur = s;
        model(s, e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so one response per cycle.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stalls", 32'({o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem}), 32'(e.stall));
            chk("flushes", 32'({o_flush_dec, o_flush_exec, o_flush_mem}), 32'(e.flush));
            chk("fwd_rs1", 32'(o_forward_rs1), 32'(e.f1));
            chk("fwd_rs2", 32'(o_forward_rs2), 32'(e.f2));
`ifdef HAZARD_PERF_EN
            chk("stall_count", o_stall_count, e.sc);
            chk("flush_count", o_flush_count, e.fc);
`endif
        end
    end

    initial begin
        stim_t s;
        s_cur = '0;
        s_cur.arst = 1'b1;
        s = '0; s.arst = 1'b1;
        apply(s); apply(s);
        // Load x5, dependent rs1 in decode; then forward from memory.
        s = '0; s.load = 1; s.rd_exec = 5; s.rs1_dec = 5; apply(s);
        s = '0; s.rd_mem = 5; s.we_mem = 1; s.rs1_exec = 5; apply(s);
        // Forwarding priority and x0.
        s = '0; s.rd_mem = 7; s.rd_wb = 7; s.we_mem = 1; s.we_wb = 1; s.rs2_exec = 7; apply(s);
        s.we_mem = 0; apply(s);
        s.rd_mem = 0; s.rd_wb = 0; s.we_mem = 1; apply(s);
        // Mispredict pulse and redirect window.
        s = '0; s.mis = 1; apply(s);
        s = '0; repeat (3) apply(s);
        // dcache stall overlapping trap and mispredict, then the trap.
        s = '0; s.dc = 1; s.trap = 1; s.mis = 1; repeat (4) apply(s);
        s = '0; s.trap = 1; apply(s);
        s = '0; apply(s);
        // icache stall with load-use.
        s = '0; s.ic = 1; s.load = 1; s.rd_exec = 3; s.rs2_dec = 3; apply(s);
        s = '0; s.ic = 1; apply(s);
        // Mispredict, dcache wait inside the redirect window, resume.
        s = '0; s.mis = 1; apply(s);
        s = '0; s.dc = 1; repeat (2) apply(s);
        s = '0; repeat (3) apply(s);
        // Reset during redirect.
        s = '0; s.mis = 1; apply(s);
        s = '0; s.arst = 1; s.ic = 1; s.we_mem = 1; s.rd_mem = 1; s.rs1_exec = 1; apply(s);
        s = '0; apply(s); apply(s);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.arst     = ($urandom_range(0, 199) == 0);
            s.rs1_dec  = AW'($urandom_range(0, 3));
            s.rs2_dec  = AW'($urandom_range(0, 3));
            s.rs1_exec = AW'($urandom_range(0, 3));
            s.rs2_exec = AW'($urandom_range(0, 3));
            s.rd_exec  = AW'($urandom_range(0, 3));
            s.rd_mem   = AW'($urandom_range(0, 3));
            s.rd_wb    = AW'($urandom_range(0, 3));
            s.load     = ($urandom_range(0, 2) == 0);
            s.we_mem   = $urandom_range(0, 1);
            s.we_wb    = $urandom_range(0, 1);
            s.mis      = ($urandom_range(0, 9) == 0);
            s.trap     = ($urandom_range(0, 24) == 0);
            s.ic       = ($urandom_range(0, 4) == 0);
            s.dc       = ($urandom_range(0, 6) == 0);
            apply(s);
        end
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge i_clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
